// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with registered operands, per-requester response channels and completion counters.
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [2:0]       req0_opc,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_opc,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    input  logic             rsp1_ready,
    output logic [2:0]       alu_opc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic [CNT_W-1:0] done0_cnt,
    output logic [CNT_W-1:0] done1_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic             r_owner;
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [WIDTH-1:0] r_rsp0_data;
    logic [WIDTH-1:0] r_rsp1_data;
    logic [2:0]       r_alu_opc;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [CNT_W-1:0] r_done0;
    logic [CNT_W-1:0] r_done1;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_ack;

    assign w_ack = r_owner ? (r_rsp1_valid & rsp1_ready) : (r_rsp0_valid & rsp0_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // On a tie, requester 0 wins unless it was the last one granted.
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        case (r_state)
            IDLE: begin
                w_grant0 = req0_valid & (~req1_valid | r_last_grant);
                w_grant1 = req1_valid & ~w_grant0;
                if (w_grant0 | w_grant1) w_state_nxt = EXEC;
            end
            EXEC:    w_state_nxt = RESP;
            RESP:    if (w_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
            r_alu_opc    <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_done0      <= '0;
            r_done1      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 | w_grant1) begin
                        r_alu_opc    <= w_grant1 ? req1_opc : req0_opc;
                        r_alu_a      <= w_grant1 ? req1_a   : req0_a;
                        r_alu_b      <= w_grant1 ? req1_b   : req0_b;
                        r_owner      <= w_grant1;
                        r_last_grant <= w_grant1;
                    end
                end
                EXEC: begin
                    if (r_owner) begin
                        r_rsp1_data  <= alu_out;
                        r_rsp1_valid <= 1'b1;
                    end else begin
                        r_rsp0_data  <= alu_out;
                        r_rsp0_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_ack) begin
                        if (r_owner) begin
                            r_rsp1_valid <= 1'b0;
                            r_done1      <= r_done1 + CNT_W'(1);
                        end else begin
                            r_rsp0_valid <= 1'b0;
                            r_done0      <= r_done0 + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready is forced low while reset is held, since IDLE alone would expose a grant.
    assign req0_ready = w_grant0 & rst_n;
    assign req1_ready = w_grant1 & rst_n;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_data  = r_rsp1_data;
    assign alu_opc    = r_alu_opc;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign done0_cnt  = r_done0;
    assign done1_cnt  = r_done1;
    assign busy       = (r_state != IDLE);

endmodule
